// File: rtl/approx_rc_adder_pipe_pkg.sv
// rtl/approx_rc_adder_pipe_pkg.sv - adder cell functions and pipeline depth helper
package approx_adder_pkg;

  // Exact full adder, returns {carry, sum}
  function automatic logic [1:0] exact_fa(input logic a, input logic b, input logic c);
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

  // Approximate cell 0_170: sum = ~c, carry = 0; the operand bits do not influence it
  function automatic logic [1:0] approx_fa_0_170(input logic a, input logic b, input logic c);
    return {1'b0 & a & b, ~c};
  endfunction

  // Number of pipeline stages needed to resolve width bits, sb bits at a time
  function automatic int n_stages(input int width, input int sb);
    return (width + sb - 1) / sb;
  endfunction

endpackage

// File: rtl/approx_rc_adder_pipe_if.sv
// rtl/approx_rc_adder_pipe_if.sv - operand and result stream bundle for the pipelined adder
interface approx_rc_adder_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_approx;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_sum;
  logic             out_approx;

  modport master (
    output in_valid, in_a, in_b, in_approx, out_ready,
    input  in_ready, out_valid, out_sum, out_approx
  );

  modport slave (
    input  in_valid, in_a, in_b, in_approx, out_ready,
    output in_ready, out_valid, out_sum, out_approx
  );
endinterface

// File: rtl/approx_rc_adder_pipe_stage.sv
// rtl/approx_rc_adder_pipe_stage.sv - one ripple slice of the adder plus its stage register
module approx_rc_stage
  import approx_adder_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int LO          = 0,
  parameter int HI          = 3,
  parameter int APPROX_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             in_valid,
  input  logic             in_mode,
  input  logic             in_carry,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_sum,
  output logic             out_valid,
  output logic             out_mode,
  output logic             out_carry,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_sum
);

  logic [WIDTH-1:0] sum_next;
  logic             carry_next;
  logic             c;
  logic [1:0]       fa;

  // Ripple through bits LO..HI, picking the approximate cell for low bits in approx mode
  always_comb begin
    sum_next = in_sum;
    c        = in_carry;
    fa       = 2'b00;
    for (int i = LO; i <= HI; i++) begin
      if (in_mode && (i < APPROX_BITS)) begin
        fa = approx_fa_0_170(in_a[i], in_b[i], c);
      end else begin
        fa = exact_fa(in_a[i], in_b[i], c);
      end
      sum_next[i] = fa[0];
      c           = fa[1];
    end
    carry_next = c;
  end

  // Stage register; the whole pipe freezes together on a stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_mode  <= 1'b0;
      out_carry <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_sum   <= '0;
    end else if (!stall) begin
      out_valid <= in_valid;
      out_mode  <= in_mode;
      out_carry <= carry_next;
      out_a     <= in_a;
      out_b     <= in_b;
      out_sum   <= sum_next;
    end
  end

endmodule

// File: rtl/approx_rc_adder_pipe.sv
// rtl/approx_rc_adder_pipe.sv - pipelined ripple-carry adder with selectable approximate LSBs
module approx_rc_adder_pipe
  import approx_adder_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int APPROX_BITS = 4,
  parameter int STAGE_BITS  = 4
) (
  input logic                  clk,
  input logic                  rst,
  approx_rc_adder_pipe_if.slave bus
);

  localparam int NSTAGES = n_stages(WIDTH, STAGE_BITS);

  // Index k is the input side of stage k; index NSTAGES is the final register
  logic             v_p [0:NSTAGES];
  logic             m_p [0:NSTAGES];
  logic             c_p [0:NSTAGES];
  logic [WIDTH-1:0] a_p [0:NSTAGES];
  logic [WIDTH-1:0] b_p [0:NSTAGES];
  logic [WIDTH-1:0] s_p [0:NSTAGES];
  logic             stall;
  logic             unused_tail;

  assign stall        = bus.out_valid & ~bus.out_ready;
  assign bus.in_ready = ~stall;

  // Bubbles enter with zeroed data so idle registers carry no stale operands
  assign v_p[0] = bus.in_valid;
  assign m_p[0] = bus.in_valid & bus.in_approx;
  assign c_p[0] = 1'b0;
  assign a_p[0] = bus.in_valid ? bus.in_a : '0;
  assign b_p[0] = bus.in_valid ? bus.in_b : '0;
  assign s_p[0] = '0;

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    localparam int LO = k * STAGE_BITS;
    localparam int HI = ((k + 1) * STAGE_BITS < WIDTH) ? (k + 1) * STAGE_BITS - 1 : WIDTH - 1;

    approx_rc_stage #(
      .WIDTH      (WIDTH),
      .LO         (LO),
      .HI         (HI),
      .APPROX_BITS(APPROX_BITS)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .stall    (stall),
      .in_valid (v_p[k]),
      .in_mode  (m_p[k]),
      .in_carry (c_p[k]),
      .in_a     (a_p[k]),
      .in_b     (b_p[k]),
      .in_sum   (s_p[k]),
      .out_valid(v_p[k+1]),
      .out_mode (m_p[k+1]),
      .out_carry(c_p[k+1]),
      .out_a    (a_p[k+1]),
      .out_b    (b_p[k+1]),
      .out_sum  (s_p[k+1])
    );
  end

  assign bus.out_valid  = v_p[NSTAGES];
  assign bus.out_approx = m_p[NSTAGES];
  assign bus.out_sum    = {c_p[NSTAGES], s_p[NSTAGES]};

  // Operands are fully consumed by the last stage
  assign unused_tail = ^{a_p[NSTAGES], b_p[NSTAGES]};

endmodule

// File: tb/tb_approx_rc_adder_pipe.sv
// tb/tb_approx_rc_adder_pipe.sv - randomized bench for approx_rc_adder_pipe against a sum model
module tb_approx_rc_adder_pipe;

  typedef struct {
    logic [12:0] a;
    logic [12:0] b;
    logic        m;
  } txn_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   n_out   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Low ab sum bits forced to 1, no carry out of them; upper part is a plain add
  function automatic logic [63:0] ref_sum(input int ab, input logic [63:0] a,
                                          input logic [63:0] b, input logic m);
    if (!m || ab == 0) return a + b;
    return (((a >> ab) + (b >> ab)) << ab) | ((64'd1 << ab) - 64'd1);
  endfunction

  approx_rc_adder_pipe_if #(.WIDTH(8)) bus ();

  approx_rc_adder_pipe #(.WIDTH(8), .APPROX_BITS(4), .STAGE_BITS(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  txn_t q[$];

  always @(negedge clk or posedge rst) begin
    txn_t e;
    if (rst) begin
      q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (q.size() == 0) begin
          check("main_unexpected_out", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          check("main_sum", bus.out_sum, ref_sum(4, e.a, e.b, e.m));
          check("main_mode", bus.out_approx, e.m);
        end
      end
      if (bus.in_valid && bus.in_ready)
        q.push_back('{{5'd0, bus.in_a}, {5'd0, bus.in_b}, bus.in_approx});
    end
  end

  localparam int SW_AB [9] = '{0, 0, 0, 5, 5, 5, 13, 13, 13};
  localparam int SW_SB [9] = '{1, 4, 13, 1, 4, 13, 1, 4, 13};

  logic        sw_valid;
  logic [12:0] sw_a;
  logic [12:0] sw_b;
  logic        sw_mode;

  for (genvar g = 0; g < 9; g++) begin : g_sw
    localparam int AB = SW_AB[g];
    localparam int SB = SW_SB[g];
    int   pending;
    txn_t sq[$];

    approx_rc_adder_pipe_if #(.WIDTH(13)) sbus ();
    assign sbus.in_valid  = sw_valid;
    assign sbus.in_a      = sw_a;
    assign sbus.in_b      = sw_b;
    assign sbus.in_approx = sw_mode;
    assign sbus.out_ready = 1'b1;

    approx_rc_adder_pipe #(.WIDTH(13), .APPROX_BITS(AB), .STAGE_BITS(SB)) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(sbus)
    );

    always @(negedge clk or posedge rst) begin
      txn_t e;
      if (rst) begin
        sq.delete();
      end else begin
        if (sbus.out_valid) begin
          if (sq.size() == 0) begin
            check($sformatf("sw%0d_unexpected_out", g), 64'd1, 64'd0);
          end else begin
            e = sq.pop_front();
            check($sformatf("sw%0d_sum", g), sbus.out_sum, ref_sum(AB, e.a, e.b, e.m));
            check($sformatf("sw%0d_mode", g), sbus.out_approx, e.m);
            if (!e.m || AB == 0)
              check($sformatf("sw%0d_exact", g), sbus.out_sum, 64'(e.a) + 64'(e.b));
            if (e.m && AB == 13)
              check($sformatf("sw%0d_all_ones", g), sbus.out_sum, 64'h1FFF);
          end
        end
        if (sbus.in_valid && sbus.in_ready) sq.push_back('{sw_a, sw_b, sw_mode});
      end
      pending = sq.size();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic m);
    int budget = 50;
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_approx = m;
    @(negedge clk);
    while (!bus.in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) check("send_timeout", 64'd0, 64'd1);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input logic [8:0] exp_sum, input logic exp_mode);
    int budget = 20;
    while (!bus.out_valid && budget > 0) begin
      step();
      budget--;
    end
    check({tag, "_valid"}, bus.out_valid, 1'b1);
    check({tag, "_sum"}, bus.out_sum, exp_sum);
    check({tag, "_mode"}, bus.out_approx, exp_mode);
  endtask

  task automatic drain(input string tag);
    int budget = 100;
    while (q.size() != 0 && budget > 0) begin
      step();
      budget--;
    end
    check(tag, q.size(), 0);
    step();
  endtask

  initial begin
    int          lat;
    int          c0;
    int          o0;
    int          stale;
    logic [8:0]  held;
    logic [7:0]  ra;
    logic [7:0]  rb;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_approx = 1'b0;
    bus.out_ready = 1'b1;
    sw_valid      = 1'b0;
    sw_a          = '0;
    sw_b          = '0;
    sw_mode       = 1'b0;

    repeat (3) step();
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_sum", bus.out_sum, 9'h000);
    check("rst_out_approx", bus.out_approx, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Exact mode and latency of NSTAGES edges counted from the accepting edge
    send(8'h25, 8'h13, 1'b0);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      step();
      lat++;
    end
    check("latency", lat, 2);
    check("exact_25_13", bus.out_sum, 9'h038);
    check("exact_25_13_mode", bus.out_approx, 1'b0);
    step();

    send(8'h25, 8'h13, 1'b1);
    wait_out("approx_25_13", 9'h03F, 1'b1);
    send(8'hFF, 8'hFF, 1'b1);
    wait_out("approx_ff_ff", 9'h1EF, 1'b1);
    drain("directed_drain");

    // Back-to-back random stream with alternating mode
    c0 = cyc;
    o0 = n_out;
    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom_range(255));
      rb = 8'($urandom_range(255));
      send(ra, rb, 1'(i % 2));
    end
    check("stream_cycles", cyc - c0, 16);
    drain("stream_drain");
    check("stream_out_count", n_out - o0, 16);

    // Stall with the pipe full: everything holds and nothing is lost
    o0 = n_out;
    send(8'h3C, 8'hA5, 1'b0);
    send(8'h7E, 8'h81, 1'b1);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_a      = 8'h5A;
    bus.in_b      = 8'hC3;
    bus.in_approx = 1'b0;
    held = bus.out_sum;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", bus.in_ready, 1'b0);
      check("stall_out_valid", bus.out_valid, 1'b1);
      check("stall_out_sum_held", bus.out_sum, held);
    end
    step();
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", bus.in_ready, 1'b1);
    step();
    bus.in_valid = 1'b0;
    drain("stall_drain");
    check("stall_out_count", n_out - o0, 3);

    // Asynchronous reset with two transactions in flight
    send(8'h11, 8'h22, 1'b0);
    send(8'h33, 8'h44, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", bus.out_valid, 1'b0);
    check("async_rst_in_ready", bus.in_ready, 1'b1);
    check("async_rst_out_sum", bus.out_sum, 9'h000);
    @(negedge clk);
    rst = 1'b0;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.out_valid) stale++;
    end
    check("no_stale_after_rst", stale, 0);
    send(8'h01, 8'h02, 1'b0);
    wait_out("post_rst", 9'h003, 1'b0);
    drain("post_rst_drain");

    // Parameter sweep, all nine instances fed the same operands
    for (int i = 0; i < 44; i++) begin
      sw_valid = 1'b1;
      if (i < 4) begin
        sw_a    = 13'h1FFF;
        sw_b    = (i < 2) ? 13'h1FFF : 13'h0001;
        sw_mode = 1'(i % 2);
      end else begin
        sw_a    = 13'($urandom_range(8191));
        sw_b    = 13'($urandom_range(8191));
        sw_mode = 1'($urandom_range(1));
      end
      step();
    end
    sw_valid = 1'b0;
    repeat (20) step();
    check("sweep_all_drained",
          g_sw[0].pending + g_sw[1].pending + g_sw[2].pending +
          g_sw[3].pending + g_sw[4].pending + g_sw[5].pending +
          g_sw[6].pending + g_sw[7].pending + g_sw[8].pending, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/approx_rc_adder_pipe.md
# approx_rc_adder_pipe

Parametrised, pipelined ripple-carry adder with a per-transaction selectable approximate low-order region. It is the registered successor to the fixed 8-bit combinational approximate ripple-carry adders. Those adders use 4 approximate LSB cells of type 0_170 and exact full adders above. This block is generalised in width, approximate-bit count and pipeline depth, and adds a valid/ready stream interface with backpressure. It sits in the adder-evaluation datapath between an operand source and an error/power measurement sink.

## Interface
- WIDTH, 8, operand width in bits (≥1)
- APPROX_BITS, 4, number of LSB positions that use the approximate cell in approx mode (0..WIDTH)
- STAGE_BITS, 4, bits resolved per pipeline stage (1..WIDTH); NSTAGES = ceil(WIDTH/STAGE_BITS)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operand transaction offered
- in_ready  output  1  block accepts transaction this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_approx  input  1  1 = approximate mode, 0 = exact mode; sampled with operands
- out_valid  output  1  result available
- out_ready  input  1  sink accepts result
- out_sum  output  WIDTH+1  sum; MSB is final carry-out
- out_approx  output  1  mode bit that travelled with this result

## Operation
- Bit i uses the exact full adder: S = a^b^c, C = maj(a,b,c).
- Exception: approximate cell 0_170 replaces it when in_approx=1 and i < APPROX_BITS.
  - Cell 0_170 outputs S = ~c and C = 0, independent of a and b.
- Carry-in to bit 0 is 0.
- Approx mode with APPROX_BITS≥1: low APPROX_BITS sum bits are all 1 (bit 0 sees c=0; every approx cell emits C=0). Carry into bit APPROX_BITS is 0.
- Exact mode, or APPROX_BITS=0: out_sum = in_a + in_b exactly, zero-extended to WIDTH+1.
- Stage k resolves bits [k*STAGE_BITS, min((k+1)*STAGE_BITS, WIDTH)-1]. It receives:
  - the registered carry from stage k-1;
  - the not-yet-added operand bits;
  - the mode bit;
  - the already-resolved sum bits.
- Last stage may be partial (WIDTH not a multiple of STAGE_BITS).
- Pipeline registers per stage: valid, mode, carry, resolved sum bits, remaining operand bits.

## Timing
- Latency: NSTAGES cycles from accepted input (in_valid & in_ready) to out_valid for that transaction, assuming no stall.
- Throughput: 1 result/cycle when out_ready held high.
- Global stall: stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - On stall, all pipeline registers hold.
  - Bubbles are not collapsed.
- out_sum and out_approx stay stable while out_valid=1 and out_ready=0.
- in_valid=0 with in_ready=1 inserts a bubble (valid=0) into stage 0.
- Results leave in acceptance order; no reordering or dropping.
- Reset (asynchronous assertion, any cycle):
  - all stage valid bits → 0, so out_valid=0 and in_ready=1;
  - out_sum, out_approx and all data registers → 0;
  - in-flight transactions are discarded, and the first valid output after reset comes from a post-reset input.
- in_approx, in_a and in_b are ignored unless in_valid & in_ready.

## Structure
- Package approx_adder_pkg holds:
  - function exact_fa(a,b,c) returning {C,S};
  - function approx_fa_0_170(a,b,c) returning {C=0,S=~c};
  - localparam helper for NSTAGES computation.
- One sub-module is natural: approx_rc_stage.
  - Parameters: LO, HI, APPROX_BITS.
  - Combinational ripple over bits LO..HI selecting the cell per bit by mode and index, plus its stage register with hold-on-stall.
- Top instantiates NSTAGES approx_rc_stage via generate and owns the handshake logic.

## Test plan
- Defaults, in_approx=0, a=0x25, b=0x13 -> out_sum=0x038, out_approx=0, 2 cycles after acceptance (NSTAGES=2).
- Defaults, in_approx=1, a=0x25, b=0x13 -> out_sum=0x03F. In the same mode, a=0xFF, b=0xFF -> out_sum=0x1EF (exact 0x1FE).
- Back-to-back stream of 16 random transactions with alternating mode and out_ready=1:
  - one result per cycle, in order;
  - each result matches the cell model;
  - out_approx echoes the input mode.
- out_ready low for 5 cycles while the pipe is full:
  - in_ready=0 throughout;
  - out_sum held constant;
  - no loss or duplication after release.
- Assert rst with 2 transactions in flight -> out_valid=0 and in_ready=1 asynchronously, and no stale result appears after reset release.
- Parameter sweep, WIDTH=13, APPROX_BITS∈{0,5,13}, STAGE_BITS∈{1,4,13}:
  - random operands match the model;
  - APPROX_BITS=0 always gives the exact sum;
  - APPROX_BITS=13 in approx mode always gives 0x1FFF with carry-out 0.
